// File: rtl/edac_mem_scrubber.sv
// Background scrubber for the EDAC-protected RAM.
// The scrubber walks every address during idle slots and reads each word
// through the Hamming decoder. It writes corrected codewords back and keeps
// saturating counts of correctable and uncorrectable errors. The user port
// always wins RAM access.
// Optional build macro EDAC_SCRUB_VERIFY_EN: after each write-back the same
// address is read again. An error on that verify read is treated as a hard
// fault.
module edac_mem_scrubber #(
  parameter int DAT_WIDTH    = 16,
  parameter int PAR_WIDTH    = 5,
  parameter int RAM_LOGDEPTH = 8,
  parameter int RD_LAT       = 1,
  parameter int SCRUB_PERIOD = 255,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           clr_cnt,
  input  logic                           user_busy,
  input  logic                           user_wEn,
  input  logic [RAM_LOGDEPTH-1:0]        user_wA,
  output logic                           scrub_rEn,
  output logic [RAM_LOGDEPTH-1:0]        scrub_rA,
  input  logic [PAR_WIDTH+DAT_WIDTH-1:0] re_code,
  input  logic                           errFlag,
  input  logic                           correctable,
  output logic                           scrub_wEn,
  output logic [RAM_LOGDEPTH-1:0]        scrub_wA,
  output logic [PAR_WIDTH+DAT_WIDTH-1:0] scrub_wD,
  output logic [CNT_WIDTH-1:0]           corr_cnt,
  output logic [CNT_WIDTH-1:0]           uncorr_cnt,
  output logic [RAM_LOGDEPTH-1:0]        uncorr_addr,
  output logic                           uncorr_pulse,
  output logic                           pass_done,
  output logic                           busy
);

  localparam int CW = PAR_WIDTH + DAT_WIDTH;
  localparam int TW = (SCRUB_PERIOD > 0) ? $clog2(SCRUB_PERIOD + 1) : 1;
  localparam int LW = $clog2(RD_LAT + 1);
  localparam logic [TW-1:0]           TIMER_LOAD = TW'(SCRUB_PERIOD);
  localparam logic [LW-1:0]           LAT_LOAD   = LW'(RD_LAT);
  localparam logic [RAM_LOGDEPTH-1:0] LAST_ADDR  = {RAM_LOGDEPTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]    CNT_MAX    = {CNT_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    READ  = 3'd2,
    LAT   = 3'd3,
    EVAL  = 3'd4,
    WRITE = 3'd5
  } state_t;

  state_t                  state_r, stateNext_s, resumeState_s;
  logic [RAM_LOGDEPTH-1:0] ptr_r;
  logic [TW-1:0]           timer_r;
  logic [LW-1:0]           latCnt_r;
  logic                    stale_r;
  logic                    snoopHit_s, staleNow_s, hardFault_s;
  logic                    issueRead_s, issueWrite_s, captureWd_s;
  logic                    uncorrEvt_s, advance_s;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] v);
    if (v == CNT_MAX) satInc = v;
    else              satInc = v + CNT_WIDTH'(1);
  endfunction

  // A user write to the word in flight makes the decoded copy stale.
  assign snoopHit_s    = user_wEn & (user_wA == ptr_r);
  assign staleNow_s    = stale_r | snoopHit_s;
  assign resumeState_s = en ? WAIT : IDLE;

`ifdef EDAC_SCRUB_VERIFY_EN
  logic verify_r;
  // Any error on a verify re-read means the write-back did not take.
  assign hardFault_s = ~correctable | verify_r;
`else
  assign hardFault_s = ~correctable;
`endif

  // The strobes are combinational so they can yield to the user in the same cycle.
  assign scrub_rEn = issueRead_s;
  assign scrub_wEn = issueWrite_s;
  assign scrub_rA  = ptr_r;
  assign scrub_wA  = ptr_r;
  assign busy      = (state_r != IDLE);

  // Next-state and per-cycle action decode.
  always_comb begin
    stateNext_s  = state_r;
    issueRead_s  = 1'b0;
    issueWrite_s = 1'b0;
    captureWd_s  = 1'b0;
    uncorrEvt_s  = 1'b0;
    advance_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (en) stateNext_s = WAIT;
        else    stateNext_s = IDLE;
      end
      WAIT: begin
        if (timer_r == {TW{1'b0}}) stateNext_s = READ;
        else                       stateNext_s = WAIT;
      end
      READ: begin
        if (user_busy) begin
          stateNext_s = READ;
        end else begin
          issueRead_s = 1'b1;
          stateNext_s = LAT;
        end
      end
      LAT: begin
        if (latCnt_r <= LW'(1)) stateNext_s = EVAL;
        else                    stateNext_s = LAT;
      end
      EVAL: begin
        if (!errFlag) begin
          advance_s   = 1'b1;
          stateNext_s = resumeState_s;
        end else if (hardFault_s) begin
          uncorrEvt_s = 1'b1;
          advance_s   = 1'b1;
          stateNext_s = resumeState_s;
        end else if (staleNow_s) begin
          advance_s   = 1'b1;
          stateNext_s = resumeState_s;
        end else begin
          captureWd_s = 1'b1;
          stateNext_s = WRITE;
        end
      end
      WRITE: begin
        if (staleNow_s) begin
          advance_s   = 1'b1;
          stateNext_s = resumeState_s;
        end else if (user_busy) begin
          stateNext_s = WRITE;
        end else begin
          issueWrite_s = 1'b1;
`ifdef EDAC_SCRUB_VERIFY_EN
          stateNext_s  = READ;
`else
          advance_s    = 1'b1;
          stateNext_s  = resumeState_s;
`endif
        end
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= stateNext_s;
  end

  // Timers, address pointer, stale tracking and captured write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r   <= {TW{1'b0}};
      latCnt_r  <= {LW{1'b0}};
      stale_r   <= 1'b0;
      ptr_r     <= {RAM_LOGDEPTH{1'b0}};
      pass_done <= 1'b0;
      scrub_wD  <= {CW{1'b0}};
    end else begin
      if ((state_r == IDLE && en) || advance_s) timer_r <= TIMER_LOAD;
      else if (state_r == WAIT && timer_r != {TW{1'b0}}) timer_r <= timer_r - TW'(1);

      if (issueRead_s) latCnt_r <= LAT_LOAD;
      else if (state_r == LAT && latCnt_r != {LW{1'b0}}) latCnt_r <= latCnt_r - LW'(1);

      if (issueRead_s) stale_r <= snoopHit_s;
      else if (snoopHit_s && (state_r == LAT || state_r == EVAL || state_r == WRITE)) stale_r <= 1'b1;

      pass_done <= advance_s && (ptr_r == LAST_ADDR);
      if (advance_s) ptr_r <= ptr_r + RAM_LOGDEPTH'(1);

      if (captureWd_s) scrub_wD <= re_code;
    end
  end

`ifdef EDAC_SCRUB_VERIFY_EN
  // Marks the re-read that follows a write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               verify_r <= 1'b0;
    else if (issueWrite_s) verify_r <= 1'b1;
    else if (advance_s)    verify_r <= 1'b0;
  end
`endif

  // Error counters and the uncorrectable report; a clear beats an increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt     <= {CNT_WIDTH{1'b0}};
      uncorr_cnt   <= {CNT_WIDTH{1'b0}};
      uncorr_addr  <= {RAM_LOGDEPTH{1'b0}};
      uncorr_pulse <= 1'b0;
    end else begin
      uncorr_pulse <= uncorrEvt_s;
      if (clr_cnt) begin
        corr_cnt    <= {CNT_WIDTH{1'b0}};
        uncorr_cnt  <= {CNT_WIDTH{1'b0}};
        uncorr_addr <= {RAM_LOGDEPTH{1'b0}};
      end else begin
        if (issueWrite_s) corr_cnt <= satInc(corr_cnt);
        if (uncorrEvt_s) begin
          uncorr_cnt  <= satInc(uncorr_cnt);
          uncorr_addr <= ptr_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_edac_mem_scrubber.sv
// Directed bench for edac_mem_scrubber with a 4-word RAM model and a
// behavioural decoder. The decoder compares each word with a golden copy:
// one flipped bit is correctable and two or more are not.
module tb_edac_mem_scrubber;
  localparam int DW = 16, PW = 5, LD = 2, RL = 1, SP = 0, CNTW = 8;
  localparam int CW = DW + PW;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst, en, clr_cnt, user_busy, user_wEn;
  logic [LD-1:0] user_wA, scrub_rA, scrub_wA, uncorr_addr;
  logic scrub_rEn, scrub_wEn, errFlag, correctable, uncorr_pulse, pass_done, busy;
  logic [CW-1:0] re_code, scrub_wD;
  logic [CNTW-1:0] corr_cnt, uncorr_cnt;

  always #5 clk = ~clk;

  edac_mem_scrubber #(.DAT_WIDTH(DW), .PAR_WIDTH(PW), .RAM_LOGDEPTH(LD), .RD_LAT(RL),
                      .SCRUB_PERIOD(SP), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .rst(rst), .en(en), .clr_cnt(clr_cnt), .user_busy(user_busy),
    .user_wEn(user_wEn), .user_wA(user_wA), .scrub_rEn(scrub_rEn), .scrub_rA(scrub_rA),
    .re_code(re_code), .errFlag(errFlag), .correctable(correctable),
    .scrub_wEn(scrub_wEn), .scrub_wA(scrub_wA), .scrub_wD(scrub_wD),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .uncorr_addr(uncorr_addr),
    .uncorr_pulse(uncorr_pulse), .pass_done(pass_done), .busy(busy)
  );

  // RAM model state
  logic [CW-1:0] ram  [0:DEPTH-1];
  logic [CW-1:0] gold [0:DEPTH-1];
  logic [CW-1:0] rdData, rdGold, userWD, diff;
  logic          initReq;
  logic [3:0]    injSingle, injDouble, injFix;
  int            nErr;

  function automatic logic [CW-1:0] pat(input int a);
    pat = CW'(32'h00005A3C + 32'(a) * 32'h00013579);
  endfunction

  // Synchronous RAM with a registered read port plus backdoor injection requests.
  always @(posedge clk) begin
    if (scrub_rEn) begin
      rdData <= ram[scrub_rA];
      rdGold <= gold[scrub_rA];
    end
    for (int a = 0; a < DEPTH; a++) begin
      if (initReq) begin
        ram[a]  <= pat(a);
        gold[a] <= pat(a);
      end else if (injSingle[a]) ram[a] <= gold[a] ^ (CW'(1) << (a + 3));
      else if (injDouble[a])     ram[a] <= gold[a] ^ (CW'(5) << a);
      else if (injFix[a])        ram[a] <= gold[a];
    end
    if (user_wEn) begin
      ram[user_wA]  <= userWD;
      gold[user_wA] <= userWD;
    end
    if (scrub_wEn) ram[scrub_wA] <= scrub_wD;
  end

  // Behavioural decoder.
  always_comb begin
    diff        = rdData ^ rdGold;
    nErr        = $countones(diff);
    errFlag     = (nErr != 0);
    correctable = (nErr == 1);
    re_code     = (nErr == 1) ? rdGold : rdData;
  end

  // Event monitor, sampled on the falling edge.
  int rdTotal = 0, wrTotal = 0, passTotal = 0, upTotal = 0, violTotal = 0;
  logic [LD-1:0] rdHist [0:7];
  logic [LD-1:0] lastWA;
  logic [CW-1:0] lastWD;
  always @(negedge clk) begin
    if (scrub_rEn) begin
      rdHist[rdTotal & 7] <= scrub_rA;
      rdTotal <= rdTotal + 1;
    end
    if (scrub_wEn) begin
      wrTotal <= wrTotal + 1;
      lastWA  <= scrub_wA;
      lastWD  <= scrub_wD;
    end
    if (pass_done)    passTotal <= passTotal + 1;
    if (uncorr_pulse) upTotal   <= upTotal + 1;
    if ((scrub_rEn || scrub_wEn) && user_busy) violTotal <= violTotal + 1;
  end

  int nChecks = 0, nFail = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitPass();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pass_done && n < 300);
    #1;
    if (!pass_done) checkVal("passTimeout", 32'd0, 32'd1);
  endtask

  task automatic waitRead(input logic [LD-1:0] addr);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(scrub_rEn && scrub_rA == addr) && n < 300);
    #1;
    if (!(scrub_rEn && scrub_rA == addr)) checkVal("readTimeout", 32'd0, 32'd1);
  endtask

  task automatic injectAll(input logic [3:0] single, input logic [3:0] dbl);
    injSingle = single;
    injDouble = dbl;
    @(posedge clk);
    #1;
    injSingle = 4'b0000;
    injDouble = 4'b0000;
  endtask

  int w0, u0;

  initial begin
    rst = 1'b1; en = 1'b0; clr_cnt = 1'b0; user_busy = 1'b0; user_wEn = 1'b0;
    user_wA = 2'd0; userWD = 21'h0; initReq = 1'b1;
    injSingle = 4'b0000; injDouble = 4'b0000; injFix = 4'b0000;
    repeat (2) @(posedge clk);
    #1 initReq = 1'b0;
    @(negedge clk);
    checkVal("rstBusy", 32'(busy), 32'd0);
    checkVal("rstREn", 32'(scrub_rEn), 32'd0);
    checkVal("rstWEn", 32'(scrub_wEn), 32'd0);
    checkVal("rstCorr", 32'(corr_cnt), 32'd0);
    checkVal("rstUncorr", 32'(uncorr_cnt), 32'd0);
    checkVal("rstPassDone", 32'(pass_done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0; en = 1'b1;

    // Clean pass
    waitPass();
    checkVal("p1Passes", 32'(passTotal), 32'd1);
    checkVal("p1Reads", 32'(rdTotal), 32'd4);
    for (int i = 0; i < 4; i++) checkVal("p1ReadAddr", 32'(rdHist[i]), 32'(i));
    checkVal("p1Writes", 32'(wrTotal), 32'd0);
    checkVal("p1Corr", 32'(corr_cnt), 32'd0);
    checkVal("p1Uncorr", 32'(uncorr_cnt), 32'd0);

    // Single-bit error at 2, double-bit error at 1
    w0 = wrTotal; u0 = upTotal;
    injectAll(4'b0100, 4'b0010);
    waitPass();
    checkVal("p2Writes", 32'(wrTotal - w0), 32'd1);
    checkVal("p2WA", 32'(lastWA), 32'd2);
    checkVal("p2WD", 32'(lastWD), 32'(pat(2)));
    checkVal("p2RamFixed", 32'(ram[2]), 32'(pat(2)));
    checkVal("p2Corr", 32'(corr_cnt), 32'd1);
    checkVal("p2Uncorr", 32'(uncorr_cnt), 32'd1);
    checkVal("p2UncorrAddr", 32'(uncorr_addr), 32'd1);
    checkVal("p2UncorrPulse", 32'(upTotal - u0), 32'd1);

    // Single-bit error at 3 overwritten by the user during LAT
    w0 = wrTotal;
    injFix = 4'b0010;
    injectAll(4'b1000, 4'b0000);
    injFix = 4'b0000;
    waitRead(2'd3);
    @(posedge clk);
    #1 user_busy = 1'b1; user_wEn = 1'b1; user_wA = 2'd3; userWD = 21'h0ABCD;
    @(posedge clk);
    #1 user_busy = 1'b0; user_wEn = 1'b0;
    waitPass();
    checkVal("p3Writes", 32'(wrTotal - w0), 32'd0);
    checkVal("p3Corr", 32'(corr_cnt), 32'd1);
    checkVal("p3UserData", 32'(ram[3]), 32'h0ABCD);
    checkVal("p3Uncorr", 32'(uncorr_cnt), 32'd1);

    // user_busy held while the scrubber waits to read
    w0 = wrTotal;
    user_busy = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkVal("stallREn", 32'(scrub_rEn), 32'd0);
    checkVal("stallBusy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 user_busy = 1'b0;
    @(negedge clk);
    checkVal("stallReleaseREn", 32'(scrub_rEn), 32'd1);
    checkVal("stallReleaseRA", 32'(scrub_rA), 32'd0);
    waitPass();
    checkVal("p4Writes", 32'(wrTotal - w0), 32'd0);

    // Reset asserted during LAT
    waitRead(2'd2);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkVal("midRstBusy", 32'(busy), 32'd0);
    checkVal("midRstREn", 32'(scrub_rEn), 32'd0);
    checkVal("midRstRA", 32'(scrub_rA), 32'd0);
    checkVal("midRstCorr", 32'(corr_cnt), 32'd0);
    checkVal("midRstUncorr", 32'(uncorr_cnt), 32'd0);
    checkVal("midRstUncorrAddr", 32'(uncorr_addr), 32'd0);
    checkVal("midRstWD", 32'(scrub_wD), 32'd0);
    injectAll(4'b1111, 4'b0000);
    @(posedge clk);
    #1 rst = 1'b0;

    // Saturation: 64 passes with 4 corrections each
    for (int i = 0; i < 64; i++) begin
      waitPass();
      injectAll(4'b1111, 4'b0000);
    end
    checkVal("satCorr", 32'(corr_cnt), 32'd255);
    w0 = wrTotal;
    waitPass();
    checkVal("satCorrHold", 32'(corr_cnt), 32'd255);
    checkVal("satWrites", 32'(wrTotal - w0), 32'd4);

    // Clear held across a pass that has both error kinds
    injectAll(4'b1101, 4'b0010);
    w0 = wrTotal; u0 = upTotal;
    clr_cnt = 1'b1;
    waitPass();
    checkVal("clrCorr", 32'(corr_cnt), 32'd0);
    checkVal("clrUncorr", 32'(uncorr_cnt), 32'd0);
    checkVal("clrUncorrAddr", 32'(uncorr_addr), 32'd0);
    checkVal("clrWrites", 32'(wrTotal - w0), 32'd3);
    checkVal("clrUncorrPulse", 32'(upTotal - u0), 32'd1);
    clr_cnt = 1'b0;

    checkVal("strobeWhileUserBusy", 32'(violTotal), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
